// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes,
// flag bit positions and controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between a requester and alu_seq.
// Signal names match the ALU's pin list.
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             execute;
  logic [3:0]       opcode;
  logic [SHW-1:0]   shift_bits;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r3;
  logic [WIDTH-1:0] r1;
  logic [3:0]       flags;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output execute, opcode, shift_bits, r2, r3,
    input  r1, flags, busy, done, err
  );

  modport slave (
    input  execute, opcode, shift_bits, r2, r3,
    output r1, flags, busy, done, err
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// valid is combinational: product is final at the coming edge.
module alu_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    valid   = busy_q && (cnt_q == CW'(WIDTH - 1));
    product = acc_nxt;
    busy    = busy_q;

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (valid) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops inline, MUL via the
// iterative multiplier; registered result, flags and pulses.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave io
);

  localparam int M = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic               mul_start, mul_busy, mul_valid;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
  logic [WIDTH-1:0] ror_w;
  logic [SHW-1:0]   rot_amt;
  logic             c, v, wr, legal, is_mul;

  alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (io.r2),
    .b       (io.r3),
    .busy    (mul_busy),
    .valid   (mul_valid),
    .product (mul_prod)
  );

  always_comb begin
    a       = io.r2;
    b       = io.r3;
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    lsl_w   = {1'b0, a} << io.shift_bits;
    lsr_w   = {a, 1'b0} >> io.shift_bits;
    rot_amt = SHW'(32'(io.shift_bits) % WIDTH);
    ror_w   = WIDTH'({a, a} >> rot_amt);

    res    = '0;
    c      = 1'b0;
    v      = 1'b0;
    wr     = 1'b1;
    legal  = 1'b1;
    is_mul = 1'b0;

    case (io.opcode)
      OP_ADD: begin
        res = add_w[M:0];
        c   = add_w[WIDTH];
        v   = (a[M] == b[M]) && (res[M] != a[M]);
      end
      OP_SUB, OP_CMP: begin
        res = sub_w[M:0];
        c   = sub_w[WIDTH];
        v   = (a[M] != b[M]) && (res[M] != a[M]);
        wr  = (io.opcode != OP_CMP);
      end
      OP_MUL: begin
        is_mul = 1'b1;
        wr     = 1'b0;
      end
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_LSL: begin
        res = lsl_w[M:0];
        c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        res = lsr_w[WIDTH:1];
        c   = lsr_w[0];
      end
      OP_ROR: begin
        res = ror_w;
        c   = (io.shift_bits != '0) && ror_w[M];
      end
      default: begin
        legal = 1'b0;
        wr    = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    r1_d      = r1_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mul_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (io.execute) begin
          done_d = !is_mul;
          err_d  = !legal;
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else if (legal) begin
            if (wr) r1_d = res;
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_N] = res[M];
            flags_d[FLAG_C] = c;
            flags_d[FLAG_V] = v;
          end
        end
      end
      S_MUL: begin
        if (mul_valid) begin
          r1_d            = mul_prod[M:0];
          flags_d[FLAG_Z] = (mul_prod[M:0] == '0);
          flags_d[FLAG_N] = mul_prod[M];
          flags_d[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
          flags_d[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
          done_d          = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r1_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Controller state is authoritative; the multiplier tracks it.
  assign io.busy  = (state_q == S_MUL) && mul_busy;
  assign io.r1    = r1_q;
  assign io.flags = flags_q;
  assign io.done  = done_q;
  assign io.err   = err_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width (>=4).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 execute  input  1  request; sampled each rising edge.
REQ-006 opcode  input  4  operation select.
REQ-007 shift_bits  input  SHW  shift/rotate amount.
REQ-008 r2  input  WIDTH  operand A.
REQ-009 r3  input  WIDTH  operand B.
REQ-010 r1  output  WIDTH  registered result.
REQ-011 flags  output  4  registered flags: [0]=Z, [1]=N, [2]=C, [3]=V.
REQ-012 busy  output  1  multi-cycle operation in progress; requests ignored.
REQ-013 done  output  1  one-cycle pulse: r1/flags just updated.
REQ-014 err  output  1  one-cycle pulse with done: illegal opcode.

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 LSL, 7 LSR, 8 ROR, 9 CMP; 10-15 illegal.
REQ-016 Request SHALL be accepted at a rising edge where execute=1 and busy=0; opcode, shift_bits, r2, r3 captured at that edge only.
REQ-017 execute while busy=1 SHALL be ignored, no queuing.
REQ-018 Non-MUL ops SHALL update r1/flags at the accepting edge; done=1 for the following cycle (latency 1).
REQ-019 MUL SHALL run as iterative shift-add: busy=1 for exactly WIDTH cycles after accept; r1/flags update and done pulses at edge WIDTH after accept; busy falls at that same edge.
REQ-020 State machine SHALL have states IDLE and MUL; IDLE->MUL on accepted MUL; MUL->IDLE when iteration count reaches WIDTH.
REQ-021 Back-to-back: a request accepted in a cycle where done=1 SHALL be honoured.
REQ-022 Results SHALL be modulo 2^WIDTH; MUL r1 = low WIDTH bits of unsigned product.
REQ-023 Z = (result==0); N = result MSB, for every legal op.
REQ-024 ADD: C = carry-out; V = signed overflow.
REQ-025 SUB/CMP: result r2-r3; C = borrow (r2<r3 unsigned); V = signed overflow.
REQ-026 CMP SHALL update flags only; r1 keeps previous value.
REQ-027 MUL: C = V = (upper WIDTH product bits nonzero).
REQ-028 OR/AND/XOR: C=V=0.
REQ-029 LSL/LSR (logical, zero fill) operate on r2 only; C = last bit shifted out; shift_bits=0 -> result=r2, C=0; V=0.
REQ-030 ROR rotates r2 right by shift_bits mod WIDTH; C = result MSB when shift_bits!=0 else 0; V=0.
REQ-031 Illegal opcode SHALL leave r1/flags unchanged and pulse done and err together, latency 1.
REQ-032 done and err SHALL be 0 in every cycle not specified above.

Reset
REQ-033 rst=1 at an edge SHALL set r1=0, flags=0, busy=0, done=0, err=0, state IDLE, iteration counter 0.
REQ-034 rst SHALL override a same-edge execute; request dropped.
REQ-035 rst during MUL SHALL abort it; no done pulse for the aborted op.

Structure
REQ-036 Package alu_pkg SHALL hold opcode constants, flag bit indices and state encoding.
REQ-037 Iterative multiplier SHALL be sub-module alu_seq_mult (start, operands, busy/valid, 2*WIDTH product); all other ops inline.

Verification (WIDTH=16)
REQ-038 ADD 0x7FFF+0x0001 -> next cycle r1=0x8000, flags N=1,V=1,C=0,Z=0, done=1 one cycle.
REQ-039 MUL 0x0100*0x0100 -> busy 16 cycles, then r1=0x0000, Z=1, C=V=1, single done; execute pulses during busy ignored.
REQ-040 CMP 0x0003 vs 0x0005 after r1=0x1234 -> r1 stays 0x1234, C=1, N=1, Z=0.
REQ-041 LSL 0x8001 by 1 -> r1=0x0002, C=1; ROR 0x0001 by 1 -> r1=0x8000, C=1, N=1; LSR by 0 -> r1=r2, C=0.
REQ-042 rst at 5th MUL cycle -> all outputs 0 next cycle, no done; following ADD 2+3 -> r1=0x0005.
REQ-043 opcode 12 -> done=err=1 one cycle, r1/flags unchanged; ADD issued in done cycle completes next cycle.
